conv_patch_scheduler: RTL

//  Sequences the sliding-window scan of one image through the convolution datapath.
//  - Fetches image rows into the line buffer over a req/ack handshake.
//  - Issues one window (patch_x, patch_y) per win_valid/win_ready handshake.
//  - Pulses cycle_detect once per accepted window, to advance the processor-enable generator.
//  - Sits between the top-level control FSM (start/done) and the line buffer + processor array.

---
 rtl/conv_sched_pkg.sv | 34 +++
 rtl/scan_pos_counter.sv | 61 ++++++
 rtl/conv_patch_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg
//   Shared types and helpers for the convolution patch scheduler.
//   - state_t      : scheduler FSM state encoding
//   - PATCH_*      : legal window edge codes (3, 5, 7)
//   - cfg_legal()  : legality check for a (patch_size, stride) pair
//   - nwin()       : window count along one image axis
package conv_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_FETCH = 3'd2,
    ST_ISSUE = 3'd3,
    ST_ADV   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [2:0] PATCH_3 = 3'd3;
  localparam logic [2:0] PATCH_5 = 3'd5;
  localparam logic [2:0] PATCH_7 = 3'd7;

  function automatic logic cfg_legal(input logic [2:0] p, input logic [2:0] s);
    return ((p == PATCH_3) || (p == PATCH_5) || (p == PATCH_7)) &&
           (s != 3'd0) && (s <= p);
  endfunction

  // Illegal combinations never reach the scan, but CHECK evaluates this
  // unconditionally, so guard the division and the underflow.
  function automatic int nwin(input int img, input int p, input int s);
    if ((s == 0) || (p > img)) return 1;
    return (img - p) / s + 1;
  endfunction

endpackage

// File: rtl/scan_pos_counter.sv
// scan_pos_counter
//   Holds the current window position and steps it in raster order.
//   Window indices (ix, iy) are tracked separately from the pixel
//   coordinates so the wrap test compares against the window count, while
//   the pixel coordinates simply accumulate the stride.
// Ports
//   clk, rst_n      clock, async active-low reset
//   clear           return to (0,0)
//   advance         step to the next window (x first, then wrap to next row)
//   step            stride S
//   nx_m1, ny_m1    window counts minus one per axis
//   patch_x/y       pixel coordinate of the current window's top-left
//   last_x/last_y   current window is the last of its row / column
module scan_pos_counter
  #(parameter int CW = 8)
  (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    input  logic [2:0]    step,
    input  logic [CW-1:0] nx_m1,
    input  logic [CW-1:0] ny_m1,
    output logic [CW-1:0] patch_x,
    output logic [CW-1:0] patch_y,
    output logic          last_x,
    output logic          last_y
  );

  logic [CW-1:0] ix;
  logic [CW-1:0] iy;

  assign last_x = (ix == nx_m1);
  assign last_y = (iy == ny_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ix      <= '0;
      iy      <= '0;
      patch_x <= '0;
      patch_y <= '0;
    end else if (clear) begin
      ix      <= '0;
      iy      <= '0;
      patch_x <= '0;
      patch_y <= '0;
    end else if (advance) begin
      if (!last_x) begin
        ix      <= ix + 1'b1;
        patch_x <= patch_x + CW'(step);
      end else if (!last_y) begin
        ix      <= '0;
        patch_x <= '0;
        iy      <= iy + 1'b1;
        patch_y <= patch_y + CW'(step);
      end
      // Last window of the image: hold; the FSM clears on its way out.
    end
  end

endmodule

// File: rtl/conv_patch_scheduler.sv
// conv_patch_scheduler
//   Sequences the sliding-window scan of one IMG_W x IMG_H image: fetches
//   rows into the line buffer (row_req/row_ack), then issues windows one at
//   a time (win_valid/win_ready), refetching S rows at each row wrap.
// Ports
//   clk, rst_n          clock, async active-low reset
//   start               begin a scan (only honoured while idle)
//   patch_size, stride  window edge P and step S, captured with start
//   row_req / row_ack   line buffer row fetch handshake
//   win_valid/win_ready window issue handshake; patch_x/patch_y = window
//   cycle_detect        pulse the cycle after each accepted window
//   busy                not idle
//   done                pulse when the final window has been accepted
//   cfg_err             pulse when start carried an illegal P/S
//   stall_cnt           (only with SCHED_STALL_CNT_EN) cycles of
//                       win_valid && !win_ready, saturating
// Configuration macro: SCHED_STALL_CNT_EN
//
// state | meaning
// IDLE  | waiting for start
// CHECK | validate P/S, latch window counts
// FETCH | request rows until rows_needed reaches zero
// ISSUE | present window, wait for win_ready
// ADV   | step position (cycle_detect high), choose next state
// DONE  | done pulse, clear position
module conv_patch_scheduler
  import conv_sched_pkg::*;
  #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int CW    = 8
  )
  (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    patch_size,
    input  logic [2:0]    stride,
    output logic          row_req,
    input  logic          row_ack,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [CW-1:0] patch_x,
    output logic [CW-1:0] patch_y,
    output logic          cycle_detect,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
`ifdef SCHED_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
  );

  state_t        state, state_nxt;
  logic [2:0]    p_lat;
  logic [2:0]    s_lat;
  logic [2:0]    rows_needed;
  logic [CW-1:0] nx_m1;
  logic [CW-1:0] ny_m1;
  logic          legal;
  logic          advance;
  logic          clear_pos;
  logic          last_x;
  logic          last_y;
  logic          cfg_err_q;

  assign legal   = cfg_legal(p_lat, s_lat);
  assign cfg_err = cfg_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    row_req      = 1'b0;
    win_valid    = 1'b0;
    cycle_detect = 1'b0;
    done         = 1'b0;
    busy         = 1'b1;
    advance      = 1'b0;
    clear_pos    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        state_nxt = legal ? ST_FETCH : ST_IDLE;
      end
      ST_FETCH: begin
        row_req = 1'b1;
        // The ack that retires the final outstanding row ends the fetch.
        if (row_ack && (rows_needed <= 3'd1)) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        win_valid = 1'b1;
        if (win_ready) state_nxt = ST_ADV;
      end
      ST_ADV: begin
        cycle_detect = 1'b1;
        advance      = 1'b1;
        if (!last_x)      state_nxt = ST_ISSUE;
        else if (!last_y) state_nxt = ST_FETCH;
        else              state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        clear_pos = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_lat       <= '0;
      s_lat       <= '0;
      rows_needed <= '0;
      nx_m1       <= '0;
      ny_m1       <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= (state == ST_CHECK) && !legal;
      if ((state == ST_IDLE) && start) begin
        p_lat <= patch_size;
        s_lat <= stride;
      end
      if (state == ST_CHECK) begin
        nx_m1 <= CW'(nwin(IMG_W, int'(p_lat), int'(s_lat)) - 1);
        ny_m1 <= CW'(nwin(IMG_H, int'(p_lat), int'(s_lat)) - 1);
        if (legal) rows_needed <= p_lat;
      end else if ((state == ST_FETCH) && row_ack && (rows_needed != 3'd0)) begin
        rows_needed <= rows_needed - 1'b1;
      end else if ((state == ST_ADV) && last_x && !last_y) begin
        // Moving down by S rows only needs the S new rows below the window.
        rows_needed <= s_lat;
      end
    end
  end

  scan_pos_counter #(.CW(CW)) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear_pos),
    .advance (advance),
    .step    (s_lat),
    .nx_m1   (nx_m1),
    .ny_m1   (ny_m1),
    .patch_x (patch_x),
    .patch_y (patch_y),
    .last_x  (last_x),
    .last_y  (last_y)
  );

`ifdef SCHED_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == ST_IDLE) && start) begin
      stall_cnt <= '0;
    end else if (win_valid && !win_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
